// File: rtl/vga_rect_writer.sv
// vga_rect_writer: filled-rectangle drawing engine for the VGA framebuffer
// write port. Accepts one command per handshake and walks the rectangle
// one pixel per clock in row-major order, suppressing plot for off-screen dots.
module vga_rect_writer #(
  parameter string RESOLUTION              = "320x240",
  parameter int    BITS_PER_COLOUR_CHANNEL = 1,
  parameter string MONOCHROME              = "FALSE",
  localparam int   XW   = (RESOLUTION == "160x120") ? 8 : 9,
  localparam int   YW   = (RESOLUTION == "160x120") ? 7 : 8,
  localparam int   XMAX = (RESOLUTION == "160x120") ? 160 : 320,
  localparam int   YMAX = (RESOLUTION == "160x120") ? 120 : 240,
  localparam int   CW   = (MONOCHROME == "TRUE") ? 1 : 3 * BITS_PER_COLOUR_CHANNEL
) (
  input  logic          vga_clock,
  input  logic          resetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [XW-1:0] cmd_x0,
  input  logic [YW-1:0] cmd_y0,
  input  logic [XW-1:0] cmd_w,
  input  logic [YW-1:0] cmd_h,
  input  logic [CW-1:0] cmd_colour,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Screen bounds in the one-bit-wider sum domain so off-screen sums never wrap.
  localparam logic [XW:0] XMAX_V = XMAX[XW:0];
  localparam logic [YW:0] YMAX_V = YMAX[YW:0];

  state_t        state_reg;
  state_t        state_next;

  logic [XW-1:0] x0_reg;
  logic [YW-1:0] y0_reg;
  logic [XW-1:0] w_reg;
  logic [YW-1:0] h_reg;
  logic [CW-1:0] colour_reg;
  logic [XW-1:0] i_reg;
  logic [YW-1:0] j_reg;

  logic          accept;
  logic          empty_cmd;
  logic          last_col;
  logic          last_row;
  logic [XW:0]   sx;
  logic [YW:0]   sy;
  logic          in_screen;

  assign accept    = (state_reg == S_IDLE) && cmd_valid;
  assign empty_cmd = (cmd_w == '0) || (cmd_h == '0);
  assign last_col  = (i_reg == (w_reg - XW'(1)));
  assign last_row  = (j_reg == (h_reg - YW'(1)));

  assign sx        = {1'b0, x0_reg} + {1'b0, i_reg};
  assign sy        = {1'b0, y0_reg} + {1'b0, j_reg};
  assign in_screen = (sx < XMAX_V) && (sy < YMAX_V);

  assign x      = sx[XW-1:0];
  assign y      = sy[YW-1:0];
  assign colour = colour_reg;

  // State register; reset abandons any rectangle in progress.
  always_ff @(posedge vga_clock) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode: empty commands skip straight to DONE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          state_next = empty_cmd ? S_DONE : S_DRAW;
        end
      end
      S_DRAW: begin
        if (last_col && last_row) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state only, so cmd_ready has no path from cmd_valid.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    plot      = 1'b0;
    case (state_reg)
      S_IDLE: cmd_ready = 1'b1;
      S_DRAW: begin
        busy = 1'b1;
        plot = in_screen;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  // Command latch and row-major pixel counters.
  always_ff @(posedge vga_clock) begin
    if (!resetn) begin
      x0_reg     <= '0;
      y0_reg     <= '0;
      w_reg      <= '0;
      h_reg      <= '0;
      colour_reg <= '0;
      i_reg      <= '0;
      j_reg      <= '0;
    end else begin
      if (accept) begin
        x0_reg     <= cmd_x0;
        y0_reg     <= cmd_y0;
        w_reg      <= cmd_w;
        h_reg      <= cmd_h;
        colour_reg <= cmd_colour;
        i_reg      <= '0;
        j_reg      <= '0;
      end else if (state_reg == S_DRAW) begin
        if (last_col) begin
          i_reg <= '0;
          if (!last_row) begin
            j_reg <= j_reg + YW'(1);
          end
        end else begin
          i_reg <= i_reg + XW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_rect_writer.sv
// tb_vga_rect_writer: randomized and directed checks of vga_rect_writer in
// both resolutions against a per-pixel arithmetic model of the rectangle walk.
module tb_vga_rect_writer;

  logic clk = 1'b0;
  logic resetn;

  // 320x240 instance
  logic       cmd_valid;
  logic       cmd_ready;
  logic [8:0] cmd_x0;
  logic [7:0] cmd_y0;
  logic [8:0] cmd_w;
  logic [7:0] cmd_h;
  logic [2:0] cmd_colour;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  // 160x120 instance
  logic       s_cmd_valid;
  logic       s_cmd_ready;
  logic [7:0] s_cmd_x0;
  logic [6:0] s_cmd_y0;
  logic [7:0] s_cmd_w;
  logic [6:0] s_cmd_h;
  logic [2:0] s_cmd_colour;
  logic [7:0] s_x;
  logic [6:0] s_y;
  logic [2:0] s_colour;
  logic       s_plot;
  logic       s_busy;
  logic       s_done;

  int total = 0;
  int bad   = 0;

  logic [31:0] o_plot, o_x, o_y, o_col, o_done, o_busy, o_ready;

  vga_rect_writer #(.RESOLUTION("320x240")) u_dut (
    .vga_clock (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x0    (cmd_x0),
    .cmd_y0    (cmd_y0),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_colour(cmd_colour),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  vga_rect_writer #(.RESOLUTION("160x120")) u_dut_s (
    .vga_clock (clk),
    .resetn    (resetn),
    .cmd_valid (s_cmd_valid),
    .cmd_ready (s_cmd_ready),
    .cmd_x0    (s_cmd_x0),
    .cmd_y0    (s_cmd_y0),
    .cmd_w     (s_cmd_w),
    .cmd_h     (s_cmd_h),
    .cmd_colour(s_cmd_colour),
    .x         (s_x),
    .y         (s_y),
    .colour    (s_colour),
    .plot      (s_plot),
    .busy      (s_busy),
    .done      (s_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Snapshot the selected instance's outputs into 32-bit holders.
  task automatic observe(input int sel);
    if (sel == 0) begin
      o_plot = 32'(plot);  o_x = 32'(x);  o_y = 32'(y);  o_col = 32'(colour);
      o_done = 32'(done);  o_busy = 32'(busy);  o_ready = 32'(cmd_ready);
    end else begin
      o_plot = 32'(s_plot);  o_x = 32'(s_x);  o_y = 32'(s_y);  o_col = 32'(s_colour);
      o_done = 32'(s_done);  o_busy = 32'(s_busy);  o_ready = 32'(s_cmd_ready);
    end
  endtask

  task automatic drive_cmd(input int sel, input int x0, input int y0, input int w,
                           input int h, input int col, input logic valid);
    if (sel == 0) begin
      cmd_valid = valid;  cmd_x0 = x0[8:0];  cmd_y0 = y0[7:0];
      cmd_w = w[8:0];  cmd_h = h[7:0];  cmd_colour = col[2:0];
    end else begin
      s_cmd_valid = valid;  s_cmd_x0 = x0[7:0];  s_cmd_y0 = y0[6:0];
      s_cmd_w = w[7:0];  s_cmd_h = h[6:0];  s_cmd_colour = col[2:0];
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive_cmd(0, 0, 0, 0, 0, 0, 1'b0);
    drive_cmd(1, 0, 0, 0, 0, 0, 1'b0);
    step();
    step();
    resetn = 1'b1;
    for (int sel = 0; sel < 2; sel++) begin
      observe(sel);
      total++;
      if (o_ready !== 1 || o_plot !== 0 || o_done !== 0 || o_busy !== 0 ||
          o_x !== 0 || o_y !== 0 || o_col !== 0)
        begin
          bad++;
          $display("FAIL reset sel=%0d: got ready=%0d plot=%0d done=%0d busy=%0d x=%0d y=%0d col=%0d, need 1 0 0 0 0 0 0",
                   sel, o_ready, o_plot, o_done, o_busy, o_x, o_y, o_col);
        end
    end
    $display("reset: checked both instances");
  endtask

  // Issue one rectangle and check every cycle against the row-major model.
  task automatic test_rect(input int sel, input int x0, input int y0, input int w,
                           input int h, input int col, input string name);
    int xmax  = (sel == 0) ? 320 : 160;
    int ymax  = (sel == 0) ? 240 : 120;
    int xmask = (sel == 0) ? 511 : 255;
    int ymask = (sel == 0) ? 255 : 127;
    int n     = w * h;
    int plots = 0;
    int exp_plots = 0;
    observe(sel);
    total++;
    if (o_ready !== 1) begin
      bad++;
      $display("FAIL %s ready-before-accept: got %0d need 1", name, o_ready);
    end
    drive_cmd(sel, x0, y0, w, h, col, 1'b1);
    step();
    // Scramble the inputs: the latched command must be unaffected.
    drive_cmd(sel, int'($urandom), int'($urandom), int'($urandom), int'($urandom),
              int'($urandom), 1'b0);
    for (int p = 0; p < n; p++) begin
      int sx = x0 + (p % w);
      int sy = y0 + (p / w);
      int ep = (sx < xmax && sy < ymax) ? 1 : 0;
      exp_plots += ep;
      observe(sel);
      plots += int'(o_plot);
      total++;
      if (o_plot !== 32'(ep) || o_busy !== 1 || o_ready !== 0 || o_done !== 0) begin
        bad++;
        $display("FAIL %s ctrl pix=%0d: got plot=%0d busy=%0d ready=%0d done=%0d, need plot=%0d busy=1 ready=0 done=0",
                 name, p, o_plot, o_busy, o_ready, o_done, ep);
      end
      total++;
      if (o_x !== 32'(sx & xmask) || o_y !== 32'(sy & ymask) || o_col !== 32'(col)) begin
        bad++;
        $display("FAIL %s pixel pix=%0d: got (%0d,%0d) col=%0d, need (%0d,%0d) col=%0d",
                 name, p, o_x, o_y, o_col, sx & xmask, sy & ymask, col);
      end
      step();
    end
    observe(sel);
    total++;
    if (o_done !== 1 || o_plot !== 0 || o_busy !== 1 || o_ready !== 0) begin
      bad++;
      $display("FAIL %s done-cycle: got done=%0d plot=%0d busy=%0d ready=%0d, need 1 0 1 0",
               name, o_done, o_plot, o_busy, o_ready);
    end
    step();
    observe(sel);
    total++;
    if (o_ready !== 1 || o_done !== 0 || o_busy !== 0 || o_plot !== 0) begin
      bad++;
      $display("FAIL %s idle-after: got ready=%0d done=%0d busy=%0d plot=%0d, need 1 0 0 0",
               name, o_ready, o_done, o_busy, o_plot);
    end
    $display("rect %s sel=%0d x0=%0d y0=%0d w=%0d h=%0d col=%0d plots=%0d expected=%0d",
             name, sel, x0, y0, w, h, col, plots, exp_plots);
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int sel = t % 2;
      int x0  = (sel == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 255));
      int y0  = (sel == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 127));
      int w   = int'($urandom_range(0, 12));
      int h   = int'($urandom_range(0, 9));
      int col = int'($urandom_range(0, 7));
      // Bias half the commands towards the bottom-right edge to exercise clipping.
      if (t % 4 < 2) begin
        x0 = ((sel == 0) ? 320 : 160) - int'($urandom_range(1, 8));
        y0 = ((sel == 0) ? 240 : 120) - int'($urandom_range(1, 5));
      end
      test_rect(sel, x0, y0, w, h, col, "random");
    end
  endtask

  // Second command held on cmd_valid must be taken in the IDLE cycle after done.
  task automatic test_back_to_back();
    drive_cmd(0, 5, 6, 3, 2, 2, 1'b1);
    step();
    drive_cmd(0, 100, 50, 2, 1, 6, 1'b1);
    for (int p = 0; p < 6; p++) begin
      observe(0);
      total++;
      if (o_plot !== 1 || o_x !== 32'(5 + p % 3) || o_y !== 32'(6 + p / 3) || o_col !== 2) begin
        bad++;
        $display("FAIL b2b first pix=%0d: got plot=%0d (%0d,%0d) col=%0d, need 1 (%0d,%0d) col=2",
                 p, o_plot, o_x, o_y, o_col, 5 + p % 3, 6 + p / 3);
      end
      step();
    end
    observe(0);
    total++;
    if (o_done !== 1 || o_ready !== 0) begin
      bad++;
      $display("FAIL b2b first done: got done=%0d ready=%0d, need 1 0", o_done, o_ready);
    end
    step();
    observe(0);
    total++;
    if (o_ready !== 1 || o_done !== 0) begin
      bad++;
      $display("FAIL b2b accept cycle: got ready=%0d done=%0d, need 1 0", o_ready, o_done);
    end
    step();
    drive_cmd(0, 0, 0, 0, 0, 0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      observe(0);
      total++;
      if (o_plot !== 1 || o_x !== 32'(100 + p) || o_y !== 50 || o_col !== 6) begin
        bad++;
        $display("FAIL b2b second pix=%0d: got plot=%0d (%0d,%0d) col=%0d, need 1 (%0d,50) col=6",
                 p, o_plot, o_x, o_y, o_col, 100 + p);
      end
      step();
    end
    observe(0);
    total++;
    if (o_done !== 1) begin
      bad++;
      $display("FAIL b2b second done: got %0d need 1", o_done);
    end
    step();
    $display("back_to_back: 3x2 then 2x1 with cmd_valid held");
  endtask

  // Reset asserted while the fourth pixel of a 4x4 is on the port.
  task automatic test_reset_mid_draw();
    int seen_done = 0;
    drive_cmd(0, 40, 40, 4, 4, 7, 1'b1);
    step();
    drive_cmd(0, 0, 0, 0, 0, 0, 1'b0);
    step();
    step();
    step();
    observe(0);
    total++;
    if (o_plot !== 1 || o_x !== 43 || o_y !== 40) begin
      bad++;
      $display("FAIL mid_reset pixel3: got plot=%0d (%0d,%0d), need 1 (43,40)", o_plot, o_x, o_y);
    end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    observe(0);
    total++;
    if (o_plot !== 0 || o_busy !== 0 || o_ready !== 1 || o_done !== 0 ||
        o_x !== 0 || o_y !== 0 || o_col !== 0)
      begin
        bad++;
        $display("FAIL mid_reset after: got plot=%0d busy=%0d ready=%0d done=%0d x=%0d y=%0d col=%0d, need 0 0 1 0 0 0 0",
                 o_plot, o_busy, o_ready, o_done, o_x, o_y, o_col);
      end
    for (int c = 0; c < 20; c++) begin
      step();
      observe(0);
      if (o_done !== 0) seen_done++;
    end
    total++;
    if (seen_done != 0) begin
      bad++;
      $display("FAIL mid_reset done pulse: got %0d done cycles, need 0", seen_done);
    end
    $display("reset_mid_draw: 4x4 abandoned at pixel 3");
  endtask

  initial begin
    test_reset();
    test_rect(0, 10, 20, 2, 2, 5, "basic");
    test_rect(0, 10, 20, 0, 5, 3, "empty_w");
    test_rect(0, 10, 20, 3, 0, 3, "empty_h");
    test_rect(1, 30, 40, 0, 0, 1, "empty_small");
    test_rect(0, 318, 239, 4, 2, 4, "clip320");
    test_rect(1, 158, 119, 4, 2, 4, "clip160");
    test_back_to_back();
    test_reset_mid_draw();
    test_random();
    test_rect(0, 0, 0, 320, 240, 0, "full_clear");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
